// File: rtl/cordic_scheduler.sv
// Round-robin front end sharing one iterative CORDIC core between requesters.
// Grants one angle, sequences load and iteration strobes, and returns a tagged result.
module cordic_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int ID_WIDTH          = 2,
  parameter int ANGLE_WIDTH       = 16,
  parameter int ITERATION_NUMBER  = 6,
  parameter int ITER_CNT_WIDTH    = 3,
  parameter int SECTOR_FLAG_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ANGLE_WIDTH-1:0]   req_degree,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [ANGLE_WIDTH-1:0]           core_degree,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     quadrant_in,
  output logic                             core_load,
  output logic                             core_iter_en,
  output logic [ITER_CNT_WIDTH-1:0]        core_iter_idx,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ID_WIDTH-1:0]              res_id,
  output logic [SECTOR_FLAG_WIDTH-1:0]     res_quadrant,
  output logic                             res_err
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic signed [ANGLE_WIDTH-1:0] MAX_DEG =
    ANGLE_WIDTH'(180);
  localparam logic signed [ANGLE_WIDTH-1:0] MIN_DEG =
    ANGLE_WIDTH'(-180);
  localparam logic [ITER_CNT_WIDTH-1:0] LAST_IDX =
    ITER_CNT_WIDTH'(ITERATION_NUMBER - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID =
    ID_WIDTH'(NUM_REQ - 1);

  state_t                         state;
  logic [ID_WIDTH-1:0]            ptr;
  logic [ID_WIDTH-1:0]            gnt_id;
  logic                           gnt_any;
  logic                           gnt_err;
  logic signed [ANGLE_WIDTH-1:0]  gnt_deg;
  int                             pos;

  // Scan from the pointer upward with wrap; first valid slot wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_deg = '0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[ID_WIDTH'(pos)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_WIDTH'(pos);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_WIDTH'(i))
        gnt_deg = req_degree[i*ANGLE_WIDTH +: ANGLE_WIDTH];
    end
  end

  assign gnt_err = (gnt_deg > MAX_DEG) || (gnt_deg < MIN_DEG);

  assign req_ready = (state == IDLE && gnt_any && !rst) ?
                     (NUM_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      core_degree   <= '0;
      core_load     <= 1'b0;
      core_iter_en  <= 1'b0;
      core_iter_idx <= '0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_quadrant  <= '0;
      res_err       <= 1'b0;
    end else begin
      core_load    <= 1'b0;
      core_iter_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            core_degree <= gnt_deg;
            res_id      <= gnt_id;
            res_err     <= gnt_err;
            ptr         <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            if (gnt_err) begin
              res_quadrant <= '0;
              res_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              core_load <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          res_quadrant  <= quadrant_in;
          core_iter_en  <= 1'b1;
          core_iter_idx <= '0;
          state         <= ITER;
        end
        ITER: begin
          if (core_iter_idx == LAST_IDX) begin
            core_iter_idx <= '0;
            res_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            core_iter_en  <= 1'b1;
            core_iter_idx <= core_iter_idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: arbitration order, strobe timing,
// backpressure, range errors and asynchronous reset.
module tb_cordic_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_degree;
  logic [3:0]  req_ready;
  logic [15:0] core_degree;
  logic [1:0]  quadrant_in;
  logic        core_load;
  logic        core_iter_en;
  logic [2:0]  core_iter_idx;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [1:0]  res_quadrant;
  logic        res_err;

  logic signed [15:0] deg [4];

  typedef struct {
    logic [1:0] id;
    logic [1:0] quad;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign req_degree = {deg[3], deg[2], deg[1], deg[0]};

  // Mapping-stage model: 0..89 ->0, 90..180 ->1, -90..-1 ->3, below ->2
  function automatic logic [1:0] quad_of(input logic signed [15:0] d);
    if (d >= 0 && d < 90) return 2'd0;
    else if (d >= 90) return 2'd1;
    else if (d >= -90) return 2'd3;
    else return 2'd2;
  endfunction

  assign quadrant_in = quad_of(core_degree);

  cordic_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_degree(req_degree),
    .req_ready(req_ready), .core_degree(core_degree),
    .quadrant_in(quadrant_in), .core_load(core_load),
    .core_iter_en(core_iter_en), .core_iter_idx(core_iter_idx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_quadrant(res_quadrant),
    .res_err(res_err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (int'(core_load) + int'(core_iter_en) + int'(res_valid) > 1) begin
        n_fail++;
        $display("FAIL exclusive: load=%0b iter=%0b valid=%0b required at most one",
                 core_load, core_iter_en, res_valid);
      end
    end
  end

  function automatic exp_t mk(input int id, input logic signed [15:0] d,
                              input logic err);
    exp_t e;
    e.id = 2'(id);
    e.quad = quad_of(d);
    e.err = err;
    return e;
  endfunction

  task automatic wait_res(output bit got);
    got = 1'b0;
    repeat (30) begin
      if (!got) begin
        @(negedge clk); #1;
        if (res_valid) got = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) deg[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready, core_degree, core_load, core_iter_en, core_iter_idx,
         res_valid, res_id, res_quadrant, res_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: load=%0b iter=%0b valid=%0b deg=%0d required all 0",
               core_load, core_iter_en, res_valid, core_degree);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: ready=%b valid=%0b required 0000/0",
               req_ready, res_valid);
    end
  endtask

  task automatic test_fairness();
    int   g = 0, last = 0;
    bit   stop = 0, done = 0;
    int   order [5] = '{0, 1, 2, 3, 0};
    exp_t e;
    @(negedge clk);
    deg[0] = 10; deg[1] = 100; deg[2] = -45; deg[3] = -120;
    res_ready = 1'b1; req_valid = 4'b1111;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      #1;
      if (res_valid) begin
        e = sb.pop_front();
        n_checks++;
        if (res_id !== e.id || res_err !== e.err || res_quadrant !== e.quad) begin
          n_fail++;
          $display("FAIL fair_result: id=%0d q=%0d err=%0b required id=%0d q=%0d err=%0b",
                   res_id, res_quadrant, res_err, e.id, e.quad, e.err);
        end
      end
      if (req_ready !== 4'b0000) begin
        n_checks++;
        if (req_ready !== (4'b0001 << order[g]) || (g > 0 && cyc - last != 9)) begin
          n_fail++;
          $display("FAIL fair_grant%0d: ready=%b gap=%0d required %b gap=9",
                   g, req_ready, cyc - last, 4'b0001 << order[g]);
        end
        sb.push_back(mk(order[g], deg[order[g]], 1'b0));
        last = cyc;
        g++;
        if (g == 5) stop = 1;
      end
      if (g == 5 && sb.size() == 0) done = 1;
      else begin
        @(negedge clk);
        if (stop) req_valid = '0;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL fair_timeout: grants=%0d pending=%0d required 5/0", g, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_skip_backpressure();
    bit   got = 0, leak = 0;
    exp_t e;
    @(negedge clk);
    res_ready = 1'b0; deg[0] = 100; deg[1] = -30;
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL skip_grant: ready=%b required 0001", req_ready);
    end
    sb.push_back(mk(0, deg[0], 1'b0));
    @(negedge clk);
    req_valid = 4'b1111;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (req_ready !== 4'b0000) leak = 1;
      if (res_valid) got = 1;
    end
    n_checks++;
    if (!got || leak) begin
      n_fail++;
      $display("FAIL busy_ignore: got=%0b leak=%0b required 1/0", got, leak);
    end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== e.id || res_quadrant !== e.quad ||
          res_err !== e.err || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold%0d: v=%0b id=%0d q=%0d ready=%b required 1/%0d/%0d/0000",
                 i, res_valid, res_id, res_quadrant, req_ready, e.id, e.quad);
      end
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL release: v=%0b ready=%b required 0/0010", res_valid, req_ready);
    end
    sb.push_back(mk(1, deg[1], 1'b0));
    @(negedge clk);
    req_valid = '0;
    wait_res(got);
    e = sb.pop_front();
    n_checks++;
    if (!got || res_id !== e.id || res_quadrant !== e.quad || res_err !== e.err) begin
      n_fail++;
      $display("FAIL next_result: got=%0b id=%0d q=%0d required id=%0d q=%0d",
               got, res_id, res_quadrant, e.id, e.quad);
    end
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    res_ready = 1'b0; deg[1] = 45; req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_grant: ready=%b required 0010", req_ready);
    end
    sb.push_back(mk(1, deg[1], 1'b0));
    @(negedge clk); #1;
    req_valid = '0;
    n_checks++;
    if (core_load !== 1'b1 || core_degree !== 16'd45 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_load: load=%0b deg=%0d required 1/45", core_load, core_degree);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (core_iter_en !== 1'b1 || core_iter_idx !== 3'(i) || core_load !== 1'b0) begin
        n_fail++;
        $display("FAIL single_iter: en=%0b idx=%0d required 1/%0d",
                 core_iter_en, core_iter_idx, i);
      end
    end
    @(negedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== e.id || res_quadrant !== e.quad ||
        res_err !== e.err) begin
      n_fail++;
      $display("FAIL single_result: v=%0b id=%0d q=%0d err=%0b required 1/%0d/%0d/%0b",
               res_valid, res_id, res_quadrant, res_err, e.id, e.quad, e.err);
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: v=%0b required 0", res_valid);
    end
  endtask

  task automatic test_range();
    bit   got;
    exp_t e;
    int   ids [3] = '{2, 3, 0};
    int   vals [3] = '{200, -180, 180};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      deg[ids[k]] = 16'(vals[k]);
      req_valid = 4'b0001 << ids[k];
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << ids[k])) begin
        n_fail++;
        $display("FAIL range_grant%0d: ready=%b required %b",
                 k, req_ready, 4'b0001 << ids[k]);
      end
      sb.push_back(mk(ids[k], deg[ids[k]], k == 0));
      @(negedge clk); #1;
      req_valid = '0;
      e = sb.pop_front();
      n_checks++;
      if (k == 0) begin
        if (core_load !== 1'b0 || core_iter_en !== 1'b0 || res_valid !== 1'b1 ||
            res_err !== 1'b1 || res_id !== e.id) begin
          n_fail++;
          $display("FAIL range_err: load=%0b iter=%0b v=%0b err=%0b id=%0d required 0/0/1/1/2",
                   core_load, core_iter_en, res_valid, res_err, res_id);
        end
      end else begin
        wait_res(got);
        if (!got || res_err !== 1'b0 || res_id !== e.id || res_quadrant !== e.quad) begin
          n_fail++;
          $display("FAIL range_edge%0d: got=%0b err=%0b id=%0d q=%0d required 1/0/%0d/%0d",
                   k, got, res_err, res_id, res_quadrant, e.id, e.quad);
        end
      end
    end
  endtask

  task automatic test_reset_mid_iter();
    bit   found = 0, got;
    exp_t e;
    @(negedge clk);
    deg[3] = 10; req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (core_iter_en && core_iter_idx == 3'd3) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reach: idx3 found=%0b required 1", found);
    end
    deg[0] = -100; req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, core_degree, core_load, core_iter_en, core_iter_idx,
         res_valid, res_id, res_quadrant, res_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: iter=%0b idx=%0d ready=%b required all 0",
               core_iter_en, core_iter_idx, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_grant: ready=%b required 0001", req_ready);
    end
    sb.push_back(mk(0, deg[0], 1'b0));
    @(negedge clk);
    req_valid = '0;
    wait_res(got);
    e = sb.pop_front();
    n_checks++;
    if (!got || res_id !== e.id || res_quadrant !== e.quad || res_err !== e.err) begin
      n_fail++;
      $display("FAIL post_reset_result: got=%0b id=%0d q=%0d required id=%0d q=%0d",
               got, res_id, res_quadrant, e.id, e.quad);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_skip_backpressure();
    test_single();
    test_range();
    test_reset_mid_iter();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
